// File: rtl/core_sram_responder.sv
// rtl/core_sram_responder.sv - byte-masked load/store responder in front of a 1RW SRAM macro
module core_sram_responder #(
    parameter logic [31:0] BASE_ADDRESS  = 32'h0000_0000,
    parameter int          ADDRESS_WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               loadEnableByteMask,
    input  logic [3:0]               storeEnableByteMask,
    input  logic [31:0]              memoryAddress,
    inout  wire  [31:0]              memoryData,
    output logic                     memoryReady,
    output logic                     memoryError,
    output logic                     sram_csb0,
    output logic                     sram_web0,
    output logic [3:0]               sram_wmask0,
    output logic [ADDRESS_WIDTH-1:0] sram_addr0,
    output logic [31:0]              sram_din0,
    input  logic [31:0]              sram_dout0
);

    localparam int TAG_LSB = ADDRESS_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] word_q;
    logic [1:0]               offset_q;
    logic                     store_q;
    logic [3:0]               mask_q;
    logic [31:0]              wdata_q;
    logic                     error_q;

    logic                     in_range;
    logic                     has_load;
    logic                     has_store;
    logic                     request;
    logic [3:0]               req_mask;
    logic [1:0]               req_offset;
    logic                     mask_ok;
    logic                     misaligned;
    logic                     capture;
    logic                     drive_en;
    logic [31:0]              drive_data;
    logic [31:0]              lane_bits;

    // Decode the window and classify the incoming request.
    always_comb begin
        in_range   = (memoryAddress[31:TAG_LSB] == BASE_ADDRESS[31:TAG_LSB]);
        has_load   = |loadEnableByteMask;
        has_store  = |storeEnableByteMask;
        request    = in_range && (has_load || has_store);
        req_mask   = has_store ? storeEnableByteMask : loadEnableByteMask;
        req_offset = memoryAddress[1:0];
        case (req_mask)
            4'b0001: mask_ok = 1'b1;
            4'b0011: mask_ok = (req_offset != 2'd3);
            4'b1111: mask_ok = (req_offset == 2'd0);
            default: mask_ok = 1'b0;
        endcase
        misaligned = !mask_ok || (has_load && has_store);
        capture    = (state_q == IDLE) && request;
    end

    // State register plus the request snapshot taken when leaving IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            word_q   <= '0;
            offset_q <= 2'd0;
            store_q  <= 1'b0;
            mask_q   <= 4'd0;
            wdata_q  <= 32'd0;
            error_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                word_q   <= memoryAddress[TAG_LSB-1:2];
                offset_q <= req_offset;
                store_q  <= has_store;
                mask_q   <= req_mask;
                wdata_q  <= memoryData;
                error_q  <= misaligned;
            end
        end
    end

    // Next state and all outputs; reset overrides so an in-flight write is cancelled.
    always_comb begin
        state_d     = state_q;
        memoryReady = 1'b0;
        memoryError = 1'b0;
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = 4'd0;
        sram_addr0  = '0;
        sram_din0   = 32'd0;
        drive_en    = 1'b0;
        drive_data  = 32'd0;
        lane_bits   = {{8{mask_q[3]}}, {8{mask_q[2]}}, {8{mask_q[1]}}, {8{mask_q[0]}}};
        case (state_q)
            IDLE: begin
                if (request) begin
                    state_d = misaligned ? RESPOND : ACCESS;
                end
            end
            ACCESS: begin
                sram_csb0  = 1'b0;
                sram_addr0 = word_q;
                if (store_q) begin
                    sram_web0   = 1'b0;
                    sram_wmask0 = mask_q << offset_q;
                    sram_din0   = wdata_q << {offset_q, 3'b000};
                end
                state_d = RESPOND;
            end
            RESPOND: begin
                memoryReady = 1'b1;
                memoryError = error_q;
                if (!store_q) begin
                    drive_en   = 1'b1;
                    drive_data = error_q ? 32'd0 : ((sram_dout0 >> {offset_q, 3'b000}) & lane_bits);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            state_d     = IDLE;
            memoryReady = 1'b0;
            memoryError = 1'b0;
            sram_csb0   = 1'b1;
            sram_web0   = 1'b1;
            sram_wmask0 = 4'd0;
            sram_addr0  = '0;
            sram_din0   = 32'd0;
            drive_en    = 1'b0;
        end
    end

    assign memoryData = drive_en ? drive_data : 32'bz;

endmodule

// File: tb/tb_core_sram_responder.sv
// tb/tb_core_sram_responder.sv - directed vector bench for core_sram_responder
module tb_core_sram_responder;

    logic        clk;
    logic        rst;
    logic [3:0]  load_mask;
    logic [3:0]  store_mask;
    logic [31:0] addr;
    wire  [31:0] memoryData;
    logic        tb_drive;
    logic [31:0] tb_data;
    logic        memoryReady;
    logic        memoryError;
    logic        sram_csb0;
    logic        sram_web0;
    logic [3:0]  sram_wmask0;
    logic [8:0]  sram_addr0;
    logic [31:0] sram_din0;
    logic [31:0] sram_dout0;

    int n_checks = 0;
    int n_fail   = 0;
    time last_ready_t = 0;

    logic [31:0] mem [0:511];

    assign memoryData = tb_drive ? tb_data : 32'bz;

    core_sram_responder #(
        .BASE_ADDRESS (32'h0000_0000),
        .ADDRESS_WIDTH(9)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .loadEnableByteMask (load_mask),
        .storeEnableByteMask(store_mask),
        .memoryAddress      (addr),
        .memoryData         (memoryData),
        .memoryReady        (memoryReady),
        .memoryError        (memoryError),
        .sram_csb0          (sram_csb0),
        .sram_web0          (sram_web0),
        .sram_wmask0        (sram_wmask0),
        .sram_addr0         (sram_addr0),
        .sram_din0          (sram_din0),
        .sram_dout0         (sram_dout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1RW SRAM: masked write, or read data registered at the capturing edge.
    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
                end
            end else begin
                sram_dout0 <= mem[sram_addr0];
            end
        end
    end

    typedef struct {
        string       name;
        logic [3:0]  lm;
        logic [3:0]  sm;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  wmask;
        logic [8:0]  waddr;
        logic [31:0] din;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  csb_cnt;
        int  lat;
        bit  got;
        csb_cnt = 0;
        lat     = 0;
        got     = 1'b0;
        @(posedge clk);
        #1;
        load_mask  = v.lm;
        store_mask = v.sm;
        addr       = v.addr;
        tb_drive   = (v.sm != 4'd0);
        tb_data    = v.wdata;
        for (int c = 1; c <= 5 && !got; c++) begin
            @(posedge clk);
            #1;
            if (!sram_csb0) begin
                csb_cnt++;
                if (v.lat == 2 && c == 1) begin
                    chk({v.name, ".addr0"}, 32'(sram_addr0), 32'(v.waddr));
                    if (v.sm != 4'd0) begin
                        chk({v.name, ".web0"}, 32'(sram_web0), 32'd0);
                        chk({v.name, ".wmask"}, 32'(sram_wmask0), 32'(v.wmask));
                        chk({v.name, ".din"}, sram_din0, v.din);
                    end else begin
                        chk({v.name, ".web0"}, 32'(sram_web0), 32'd1);
                        chk({v.name, ".wmask"}, 32'(sram_wmask0), 32'd0);
                    end
                end
            end
            if (memoryReady) begin
                got = 1'b1;
                lat = c;
                last_ready_t = $time;
            end
        end
        chk({v.name, ".latency"}, 32'(lat), 32'(v.lat));
        chk({v.name, ".csb_strobes"}, 32'(csb_cnt), (v.lat == 2) ? 32'd1 : 32'd0);
        if (got) begin
            chk({v.name, ".error"}, 32'(memoryError), 32'(v.err));
            if (v.sm == 4'd0) chk({v.name, ".rdata"}, memoryData, v.rdata);
        end
        load_mask  = 4'd0;
        store_mask = 4'd0;
        tb_drive   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        time  prev_t;
        logic [31:0] b2b_addr [4];
        logic [31:0] b2b_data [4];

        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        sram_dout0 = 32'd0;

        //           name            lm    sm    addr          wdata         lat err  rdata         wmask waddr din
        vecs[0]  = '{"sw_word",      4'h0, 4'hF, 32'h010, 32'hDEADBEEF, 2, 1'b0, 32'h0,        4'hF, 9'd4, 32'hDEADBEEF};
        vecs[1]  = '{"lw_word",      4'hF, 4'h0, 32'h010, 32'h0,        2, 1'b0, 32'hDEADBEEF, 4'h0, 9'd4, 32'h0};
        vecs[2]  = '{"sb_hi",        4'h0, 4'h1, 32'h013, 32'h000000A5, 2, 1'b0, 32'h0,        4'h8, 9'd4, 32'hA5000000};
        vecs[3]  = '{"lw_merged",    4'hF, 4'h0, 32'h010, 32'h0,        2, 1'b0, 32'hA5ADBEEF, 4'h0, 9'd4, 32'h0};
        vecs[4]  = '{"lbu_hi",       4'h1, 4'h0, 32'h013, 32'h0,        2, 1'b0, 32'h000000A5, 4'h0, 9'd4, 32'h0};
        vecs[5]  = '{"lh_hi",        4'h3, 4'h0, 32'h012, 32'h0,        2, 1'b0, 32'h0000A5AD, 4'h0, 9'd4, 32'h0};
        vecs[6]  = '{"lh_mis",       4'h3, 4'h0, 32'h003, 32'h0,        1, 1'b1, 32'h0,        4'h0, 9'd0, 32'h0};
        vecs[7]  = '{"sw_mis",       4'h0, 4'hF, 32'h006, 32'h11111111, 1, 1'b1, 32'h0,        4'h0, 9'd0, 32'h0};
        vecs[8]  = '{"lw_after_mis", 4'hF, 4'h0, 32'h004, 32'h0,        2, 1'b0, 32'h0,        4'h0, 9'd1, 32'h0};
        vecs[9]  = '{"both_masks",   4'hF, 4'hF, 32'h010, 32'h0,        1, 1'b1, 32'h0,        4'h0, 9'd0, 32'h0};
        vecs[10] = '{"bad_mask",     4'h7, 4'h0, 32'h000, 32'h0,        1, 1'b1, 32'h0,        4'h0, 9'd0, 32'h0};
        vecs[11] = '{"sh_hi",        4'h0, 4'h3, 32'h022, 32'h0000BEEF, 2, 1'b0, 32'h0,        4'hC, 9'd8, 32'hBEEF0000};
        vecs[12] = '{"lw_020",       4'hF, 4'h0, 32'h020, 32'h0,        2, 1'b0, 32'hBEEF0000, 4'h0, 9'd8, 32'h0};
        vecs[13] = '{"sb_lane1",     4'h0, 4'h1, 32'h001, 32'h0000005A, 2, 1'b0, 32'h0,        4'h2, 9'd0, 32'h00005A00};
        vecs[14] = '{"lh_off1",      4'h3, 4'h0, 32'h001, 32'h0,        2, 1'b0, 32'h0000005A, 4'h0, 9'd0, 32'h0};
        vecs[15] = '{"lw_oor",       4'hF, 4'h0, 32'h800, 32'h0,        0, 1'b0, 32'h0,        4'h0, 9'd0, 32'h0};
        vecs[16] = '{"sw_oor",       4'h0, 4'hF, 32'h804, 32'hCAFEF00D, 0, 1'b0, 32'h0,        4'h0, 9'd0, 32'h0};
        vecs[17] = '{"lw_alias",     4'hF, 4'h0, 32'h004, 32'h0,        2, 1'b0, 32'h0,        4'h0, 9'd1, 32'h0};

        rst        = 1'b1;
        load_mask  = 4'd0;
        store_mask = 4'd0;
        addr       = 32'd0;
        tb_drive   = 1'b0;
        tb_data    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.ready", 32'(memoryReady), 32'd0);
        chk("reset.error", 32'(memoryError), 32'd0);
        chk("reset.csb0", 32'(sram_csb0), 32'd1);
        chk("reset.web0", 32'(sram_web0), 32'd1);
        chk("reset.wmask", 32'(sram_wmask0), 32'd0);
        chk("reset.addr0", 32'(sram_addr0), 32'd0);
        chk("reset.din0", sram_din0, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) run_vec(vecs[i]);

        // Reset asserted while a store sits in ACCESS must cancel the write.
        @(posedge clk);
        #1;
        store_mask = 4'hF;
        addr       = 32'h020;
        tb_drive   = 1'b1;
        tb_data    = 32'h12345678;
        @(posedge clk);
        #1;
        chk("rst_mid.csb0_before", 32'(sram_csb0), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_mid.csb0", 32'(sram_csb0), 32'd1);
        chk("rst_mid.web0", 32'(sram_web0), 32'd1);
        chk("rst_mid.ready", 32'(memoryReady), 32'd0);
        store_mask = 4'd0;
        tb_drive   = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid.ready_after", 32'(memoryReady), 32'd0);
        chk("rst_mid.csb0_after", 32'(sram_csb0), 32'd1);
        rst = 1'b0;
        v = vecs[12];
        v.name = "rst_mid.lw_020";
        run_vec(v);

        // Back-to-back word loads: each completes exactly three cycles after the previous.
        b2b_addr[0] = 32'h010; b2b_data[0] = 32'hA5ADBEEF;
        b2b_addr[1] = 32'h020; b2b_data[1] = 32'hBEEF0000;
        b2b_addr[2] = 32'h000; b2b_data[2] = 32'h00005A00;
        b2b_addr[3] = 32'h010; b2b_data[3] = 32'hA5ADBEEF;
        prev_t = 0;
        for (int i = 0; i < 4; i++) begin
            v = '{"b2b_lw", 4'hF, 4'h0, b2b_addr[i], 32'h0, 2, 1'b0, b2b_data[i],
                  4'h0, b2b_addr[i][10:2], 32'h0};
            run_vec(v);
            if (i > 0) chk("b2b.spacing", 32'(last_ready_t - prev_t), 32'd30);
            prev_t = last_ready_t;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_sram_responder.md
Name: core_sram_responder

Overview:
- Memory-side responder for the RV32I core's byte-masked load/store bus.
- Decodes an address window and serves loads and stores from a single-port SRAM macro: 1RW, active-low chip select and write enable, per-byte write mask, read data valid the cycle after the capturing edge.
- Handles lane alignment, misalignment errors and the handshake.
- Several instances may share one core bus; an instance only drives the bus inside its own window.

Parameters:
- BASE_ADDRESS, 32'h0000_0000: byte base of the window; bits [ADDRESS_WIDTH+1:0] are ignored.
- ADDRESS_WIDTH, 9: SRAM word-address width. Window size is 4*2^ADDRESS_WIDTH bytes.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- loadEnableByteMask  input  4  core load request, LSB-justified lane mask (0001 byte, 0011 half, 1111 word)
- storeEnableByteMask  input  4  core store request, same encoding
- memoryAddress  input  32  core byte address
- memoryData  inout  32  shared data bus: core drives it on stores, responder drives it on loads, otherwise Z
- memoryReady  output  1  one-cycle access-complete strobe
- memoryError  output  1  valid with memoryReady; 1 = access rejected
- sram_csb0  output  1  SRAM chip select, active low
- sram_web0  output  1  SRAM write enable, active low
- sram_wmask0  output  4  SRAM byte write mask
- sram_addr0  output  ADDRESS_WIDTH  SRAM word address
- sram_din0  output  32  SRAM write data
- sram_dout0  input  32  SRAM read data

Behaviour:
- Reset state: state=IDLE, memoryReady=0, memoryError=0, sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0, memoryData=Z.
- inRange: memoryAddress[31:ADDRESS_WIDTH+2] == BASE_ADDRESS[31:ADDRESS_WIDTH+2].
- request: inRange and (|loadEnableByteMask or |storeEnableByteMask).
- offset: memoryAddress[1:0].
- misaligned (any one is enough):
  - mask not one of 0001/0011/1111;
  - mask 0011 with offset 3;
  - mask 1111 with offset != 0;
  - load and store masks both nonzero.
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE:
  - On request, latch address word, offset, direction, mask and store data (memoryData).
  - Go to RESPOND with error flag set if misaligned; otherwise go to ACCESS.
  - With no request, stay in IDLE.
  - Out-of-range requests are ignored entirely: no strobe, bus stays Z.
- ACCESS (exactly one cycle):
  - sram_csb0=0, sram_addr0=latched word address.
  - Store: sram_web0=0, sram_wmask0=mask<<offset, sram_din0=storeData<<(8*offset).
  - Load: sram_web0=1, sram_wmask0=0.
  - Next state RESPOND.
- RESPOND (exactly one cycle):
  - memoryReady=1; memoryError=latched error flag.
  - Load: drive memoryData = (sram_dout0>>(8*offset)) ANDed with the mask expanded to bytes. Upper lanes are zero; sign extension is the core's job.
  - Errored load: drive 32'h0.
  - Store: memoryData stays Z.
  - Next state IDLE.
- Latency: request sampled at edge E0. Good access gives memoryReady during the cycle after E1. Misaligned access gives memoryReady during the cycle after E0. Good access occupies 3 cycles IDLE→IDLE.
- Request changes after the IDLE latch are ignored until RESPOND completes.
- A request still present on return to IDLE is treated as a new access. The core must change or drop its request on seeing memoryReady.
- Outside ACCESS, sram_csb0=1 and sram_web0=1. The SRAM is never strobed for erroring or out-of-range requests.
- sram_csb0 and sram_web0 are forced to 1 combinationally while rst=1, so a write in ACCESS in the reset cycle is cancelled.
- Reset in any state: next state IDLE, memoryReady=0, bus released to Z.
- Wrap-around: none inside the window; any address outside it is simply not claimed.

Test Plan:
- Word round trip at BASE=0:
  - SW addr 0x010, data 0xDEADBEEF → ACCESS with wmask 1111, addr0=4, ready at +2 cycles, error=0.
  - LW 0x010 → memoryData=0xDEADBEEF with ready.
- Byte lanes:
  - After the word above, SB 0x013 data 0x000000A5 → wmask 1000, din 0xA5000000.
  - LW 0x010 → 0xA5ADBEEF.
  - LBU 0x013 → 0x000000A5.
  - LH 0x012 → 0x0000A5AD.
- Misalignment:
  - LH 0x003 → ready one cycle after request, error=1, data 0, csb0 stays 1.
  - SW 0x006 → error=1, memory unchanged; verify by a following LW.
  - Simultaneous load and store masks → error=1.
- Out of range (ADDRESS_WIDTH=9): LW 0x800 → memoryReady never asserts, memoryData Z, csb0 stays 1 for 5 cycles.
- Reset mid-write: SW 0x020 data 0x12345678, rst=1 during ACCESS → csb0=1 that cycle, no ready; LW 0x020 afterwards returns the prior value.
- Back-to-back: 4 consecutive LWs held until ready → each completes in 3 cycles, correct data, no overlapping strobes.
